// File: rtl/multicycle_main_controller.sv
// ---------------------------------------------------------------------------
// multicycle_main_controller
//
// Moore-FSM main control unit for the multi-cycle MIPS datapath. Each
// instruction steps through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK
// states. The FSM stalls in FETCH, MEMRD and MEMWR until the shared memory
// signals ready. Unsupported opcodes raise a one-cycle illegal_op pulse in
// DECODE, and the FSM then returns to FETCH.
//
// Parameters
//   OPCODE_W  opcode field width
//   ALUOP_W   alu_op width (>=2). Bits above bit 1 are always zero.
//   BNE_EN    1: opcode 000101 decodes as BNE. 0: it is treated as illegal.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   opcode                    instr[31:26] from the instruction register
//   mem_ready                 memory completes the current access this cycle
//   pc_write/branch/branch_ne PC load: unconditional, on zero, on not-zero
//   i_or_d                    memory address select (0 PC, 1 ALUOut)
//   mem_read/mem_write        memory request strobes
//   ir_write                  instruction register load
//   mem_to_reg/reg_dst        writeback source and destination selects
//   reg_write                 register file write
//   alu_src_a/alu_src_b       ALU operand selects
//   alu_op                    00 add, 01 sub, 10 funct-decoded
//   pc_src                    00 ALU, 01 ALUOut, 10 jump target
//   illegal_op                pulse on an unsupported opcode
// ---------------------------------------------------------------------------
module multicycle_main_controller #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter bit BNE_EN   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                branch,
    output logic                branch_ne,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_src,
    output logic                illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = '0;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

    state_e state_q, state_d;
    logic   is_beq, is_bne, dec_illegal;

    // A disabled BNE is simply not recognised, so it falls into the illegal path.
    assign is_beq = (opcode == OP_BEQ);
    assign is_bne = BNE_EN && (opcode == OP_BNE);

    // Next-state logic
    always_comb begin
        // NOTE: every variable gets a default before the case; a path that leaves one unassigned infers a latch.
        state_d     = state_q;
        dec_illegal = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
                else if (opcode == OP_R)                state_d = S_EXEC;
                else if (opcode == OP_ADDI)             state_d = S_ADDIEX;
                else if (is_beq || is_bne)              state_d = S_BRANCH;
                else if (opcode == OP_J)                state_d = S_JUMP;
                else begin
                    state_d     = S_FETCH;
                    dec_illegal = 1'b1;
                end
            end
            // The IR holds the instruction, so opcode still selects lw or sw here.
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;  // MEMWB, ALUWB, ADDIWB, BRANCH, JUMP
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // The outputs are decoded from state_q. In FETCH, pc_write and ir_write
    // also depend on mem_ready. All outputs are forced to zero during reset,
    // so no write strobe can fire on the reset cycle.
    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        pc_src     = 2'b00;
        illegal_op = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_write  = mem_ready;
                    ir_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = dec_illegal;
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_ADDIWB: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = 2'b01;
                    branch    = is_beq;
                    branch_ne = is_bne;
                end
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_main_controller
//
// Self-checking bench for multicycle_main_controller. Two instances run side
// by side, one with BNE_EN=1 and one with BNE_EN=0. Each scenario pushes the
// expected output vector for every cycle into a per-instance queue. The cycle
// task then pops each entry and compares it on the falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_main_controller;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } exp_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;

    logic       pc_write1, branch1, branch_ne1, i_or_d1, mem_read1, mem_write1, ir_write1;
    logic       mem_to_reg1, reg_dst1, reg_write1, alu_src_a1, illegal_op1;
    logic [1:0] alu_src_b1, alu_op1, pc_src1;
    logic       pc_write0, branch0, branch_ne0, i_or_d0, mem_read0, mem_write0, ir_write0;
    logic       mem_to_reg0, reg_dst0, reg_write0, alu_src_a0, illegal_op0;
    logic [1:0] alu_src_b0, alu_op0, pc_src0;
    exp_t       o1, o0;

    multicycle_main_controller #(.OPCODE_W(6), .ALUOP_W(2), .BNE_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write1), .branch(branch1), .branch_ne(branch_ne1), .i_or_d(i_or_d1),
        .mem_read(mem_read1), .mem_write(mem_write1), .ir_write(ir_write1),
        .mem_to_reg(mem_to_reg1), .reg_dst(reg_dst1), .reg_write(reg_write1),
        .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_op(alu_op1),
        .pc_src(pc_src1), .illegal_op(illegal_op1)
    );

    multicycle_main_controller #(.OPCODE_W(6), .ALUOP_W(2), .BNE_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write0), .branch(branch0), .branch_ne(branch_ne0), .i_or_d(i_or_d0),
        .mem_read(mem_read0), .mem_write(mem_write0), .ir_write(ir_write0),
        .mem_to_reg(mem_to_reg0), .reg_dst(reg_dst0), .reg_write(reg_write0),
        .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0),
        .pc_src(pc_src0), .illegal_op(illegal_op0)
    );

    assign o1 = {pc_write1, branch1, branch_ne1, i_or_d1, mem_read1, mem_write1, ir_write1,
                 mem_to_reg1, reg_dst1, reg_write1, alu_src_a1, alu_src_b1, alu_op1,
                 pc_src1, illegal_op1};
    assign o0 = {pc_write0, branch0, branch_ne0, i_or_d0, mem_read0, mem_write0, ir_write0,
                 mem_to_reg0, reg_dst0, reg_write0, alu_src_a0, alu_src_b0, alu_op0,
                 pc_src0, illegal_op0};

    always #5 clk = ~clk;

    exp_t  q1[$];
    exp_t  q0[$];
    int    checks   = 0;
    int    failures = 0;
    string cur_test = "";

    // ---------------- expected vectors, one per controller state ----------
    function automatic exp_t e_zero();
        exp_t e = '0;
        return e;
    endfunction
    function automatic exp_t e_fetch(input logic rdy);
        exp_t e = '0;
        e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.pc_write = rdy; e.ir_write = rdy;
        return e;
    endfunction
    function automatic exp_t e_decode(input logic ill);
        exp_t e = '0;
        e.alu_src_b = 2'b11; e.illegal_op = ill;
        return e;
    endfunction
    function automatic exp_t e_memadr();  // also ADDIEX
        exp_t e = '0;
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        return e;
    endfunction
    function automatic exp_t e_memrd();
        exp_t e = '0;
        e.i_or_d = 1'b1; e.mem_read = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_memwb();
        exp_t e = '0;
        e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_memwr();
        exp_t e = '0;
        e.i_or_d = 1'b1; e.mem_write = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_exec();
        exp_t e = '0;
        e.alu_src_a = 1'b1; e.alu_op = 2'b10;
        return e;
    endfunction
    function automatic exp_t e_aluwb();
        exp_t e = '0;
        e.reg_write = 1'b1; e.reg_dst = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_addiwb();
        exp_t e = '0;
        e.reg_write = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_branch(input logic beq, input logic bne);
        exp_t e = '0;
        e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01;
        e.branch = beq; e.branch_ne = bne;
        return e;
    endfunction
    function automatic exp_t e_jump();
        exp_t e = '0;
        e.pc_src = 2'b10; e.pc_write = 1'b1;
        return e;
    endfunction

    // ---------------- scoreboard plumbing ----------------------------------
    task automatic exp2(input exp_t e);
        q1.push_back(e);
        q0.push_back(e);
    endtask

    // Drive one cycle of inputs and compare mid-cycle against the queued expectations.
    task automatic cyc(input logic r, input logic [5:0] op, input logic rdy);
        exp_t e;
        rst = r; opcode = op; mem_ready = rdy;
        @(negedge clk);
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if (o1 !== e) begin
                failures++;
                $display("FAIL %s [BNE_EN=1] outputs got=%h expected=%h", cur_test, o1, e);
            end
        end
        if (q0.size() > 0) begin
            e = q0.pop_front();
            checks++;
            if (o0 !== e) begin
                failures++;
                $display("FAIL %s [BNE_EN=0] outputs got=%h expected=%h", cur_test, o0, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp2(e_zero());
        cyc(1'b1, OP_R, 1'b1);
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        cur_test = "reset";
        // mem_ready is high during reset, so an unforced FETCH would show pc_write.
        exp2(e_zero());       cyc(1'b1, OP_R, 1'b1);
        exp2(e_zero());       cyc(1'b1, OP_R, 1'b1);
        exp2(e_fetch(1'b1));  cyc(1'b0, OP_R, 1'b1);
    endtask

    task automatic test_lw();
        cur_test = "lw";
        do_reset();
        exp2(e_fetch(1'b1));  cyc(1'b0, OP_LW, 1'b1);
        exp2(e_decode(1'b0)); cyc(1'b0, OP_LW, 1'b1);
        exp2(e_memadr());     cyc(1'b0, OP_LW, 1'b1);
        exp2(e_memrd());      cyc(1'b0, OP_LW, 1'b1);
        exp2(e_memwb());      cyc(1'b0, OP_LW, 1'b1);
        exp2(e_fetch(1'b0));  cyc(1'b0, OP_LW, 1'b0);
    endtask

    task automatic test_sw_stall();
        cur_test = "sw_stall";
        do_reset();
        exp2(e_fetch(1'b1));  cyc(1'b0, OP_SW, 1'b1);
        exp2(e_decode(1'b0)); cyc(1'b0, OP_SW, 1'b1);
        exp2(e_memadr());     cyc(1'b0, OP_SW, 1'b1);
        for (int i = 0; i < 3; i++) begin
            exp2(e_memwr());  cyc(1'b0, OP_SW, 1'b0);
        end
        exp2(e_memwr());      cyc(1'b0, OP_SW, 1'b1);
        exp2(e_fetch(1'b0));  cyc(1'b0, OP_SW, 1'b0);
    endtask

    task automatic test_rtype();
        cur_test = "rtype";
        do_reset();
        exp2(e_fetch(1'b1));  cyc(1'b0, OP_R, 1'b1);
        exp2(e_decode(1'b0)); cyc(1'b0, OP_R, 1'b1);
        exp2(e_exec());       cyc(1'b0, OP_R, 1'b1);
        exp2(e_aluwb());      cyc(1'b0, OP_R, 1'b1);
        exp2(e_fetch(1'b0));  cyc(1'b0, OP_R, 1'b0);
    endtask

    task automatic test_beq();
        cur_test = "beq";
        do_reset();
        exp2(e_fetch(1'b1));         cyc(1'b0, OP_BEQ, 1'b1);
        exp2(e_decode(1'b0));        cyc(1'b0, OP_BEQ, 1'b1);
        exp2(e_branch(1'b1, 1'b0));  cyc(1'b0, OP_BEQ, 1'b1);
        exp2(e_fetch(1'b0));         cyc(1'b0, OP_BEQ, 1'b0);
    endtask

    task automatic test_bne();
        cur_test = "bne";
        do_reset();
        exp2(e_fetch(1'b1));             cyc(1'b0, OP_BNE, 1'b1);
        q1.push_back(e_decode(1'b0));
        q0.push_back(e_decode(1'b1));    cyc(1'b0, OP_BNE, 1'b1);
        // With mem_ready low, the BNE_EN=0 instance waits in FETCH while the other branches.
        q1.push_back(e_branch(1'b0, 1'b1));
        q0.push_back(e_fetch(1'b0));     cyc(1'b0, OP_BNE, 1'b0);
        exp2(e_fetch(1'b0));             cyc(1'b0, OP_BNE, 1'b0);
    endtask

    task automatic test_illegal();
        cur_test = "illegal";
        do_reset();
        exp2(e_fetch(1'b1));  cyc(1'b0, OP_BAD, 1'b1);
        exp2(e_decode(1'b1)); cyc(1'b0, OP_BAD, 1'b1);
        exp2(e_fetch(1'b0));  cyc(1'b0, OP_BAD, 1'b0);
        exp2(e_fetch(1'b0));  cyc(1'b0, OP_BAD, 1'b0);
    endtask

    task automatic test_fetch_stall_reset();
        cur_test = "fetch_stall_reset";
        do_reset();
        exp2(e_fetch(1'b0));  cyc(1'b0, OP_R, 1'b0);
        exp2(e_fetch(1'b0));  cyc(1'b0, OP_R, 1'b0);
        exp2(e_zero());       cyc(1'b1, OP_R, 1'b0);
        exp2(e_fetch(1'b0));  cyc(1'b0, OP_R, 1'b0);
        exp2(e_fetch(1'b1));  cyc(1'b0, OP_R, 1'b1);
        exp2(e_decode(1'b0)); cyc(1'b0, OP_R, 1'b1);
    endtask

    task automatic test_reset_mid_instr();
        cur_test = "reset_mid_lw";
        do_reset();
        exp2(e_fetch(1'b1));  cyc(1'b0, OP_LW, 1'b1);
        exp2(e_decode(1'b0)); cyc(1'b0, OP_LW, 1'b1);
        exp2(e_memadr());     cyc(1'b0, OP_LW, 1'b1);
        exp2(e_memrd());      cyc(1'b0, OP_LW, 1'b0);
        exp2(e_zero());       cyc(1'b1, OP_LW, 1'b1);
        exp2(e_fetch(1'b0));  cyc(1'b0, OP_LW, 1'b0);
    endtask

    task automatic test_back_to_back();
        cur_test = "addi_then_j";
        do_reset();
        exp2(e_fetch(1'b1));  cyc(1'b0, OP_ADDI, 1'b1);
        exp2(e_decode(1'b0)); cyc(1'b0, OP_ADDI, 1'b1);
        exp2(e_memadr());     cyc(1'b0, OP_ADDI, 1'b1);
        exp2(e_addiwb());     cyc(1'b0, OP_ADDI, 1'b1);
        exp2(e_fetch(1'b1));  cyc(1'b0, OP_J, 1'b1);
        exp2(e_decode(1'b0)); cyc(1'b0, OP_J, 1'b1);
        exp2(e_jump());       cyc(1'b0, OP_J, 1'b1);
        exp2(e_fetch(1'b0));  cyc(1'b0, OP_J, 1'b0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_lw();
        test_sw_stall();
        test_rtype();
        test_beq();
        test_bne();
        test_illegal();
        test_fetch_stall_reset();
        test_reset_mid_instr();
        test_back_to_back();
        checks++;
        if (q1.size() + q0.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain leftover=%0d expected=0", q1.size() + q0.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
